// File: rtl/e203_exu_irbuf.sv
// e203_exu_irbuf: in-order instruction buffer between the IFU and the decoder.
// Configuration macro: E203_IRBUF_2DEPTH_EN
//   defined   -> two entries, ifu_o_ready depends only on registered occupancy
//   undefined -> one entry, ifu_o_ready also opens when decode pops this cycle
// Payload leaves from registers only; nothing on ifu_o_* reaches ir_o_* in the same cycle.
module e203_exu_irbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_o_valid,
  output logic        ifu_o_ready,
  input  logic [31:0] ifu_o_ir,
  input  logic [31:0] ifu_o_pc,
  input  logic        ifu_o_prdt_taken,
  input  logic        ifu_o_misalgn,
  input  logic        ifu_o_buserr,
  input  logic        ifu_o_muldiv_b2b,
  input  logic        pipe_flush_req,
  output logic        ir_o_valid,
  input  logic        ir_o_ready,
  output logic [31:0] ir_o_instr,
  output logic [31:0] ir_o_pc,
  output logic        ir_o_prdt_taken,
  output logic        ir_o_misalgn,
  output logic        ir_o_buserr,
  output logic        ir_o_muldiv_b2b
);

  localparam int INSTR_SIZE = 32;
  localparam int PC_SIZE    = 32;
`ifdef E203_IRBUF_2DEPTH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // One buffered instruction with the sideband flags that travel with it.
  typedef struct packed {
    logic [INSTR_SIZE-1:0] ir;
    logic [PC_SIZE-1:0]    pc;
    logic                  prdt_taken;
    logic                  misalgn;
    logic                  buserr;
    logic                  muldiv_b2b;
  } entry_t;

  entry_t     ent_q [DEPTH];
  entry_t     ent_d [DEPTH];
  logic [1:0] count_q;
  logic [1:0] count_d;
`ifdef E203_IRBUF_2DEPTH_EN
  logic       wptr_q;
  logic       wptr_d;
  logic       rptr_q;
  logic       rptr_d;
`endif

  entry_t     in_s;
  entry_t     head_s;
  logic       push_s;
  logic       pop_s;

  // Handshakes, head selection and the payload presented to decode.
  always_comb begin
    in_s = {ifu_o_ir, ifu_o_pc, ifu_o_prdt_taken, ifu_o_misalgn,
            ifu_o_buserr, ifu_o_muldiv_b2b};
`ifdef E203_IRBUF_2DEPTH_EN
    ifu_o_ready = (count_q < 2'd2);
    head_s      = ent_q[rptr_q];
`else
    ifu_o_ready = (count_q == 2'd0) | ir_o_ready;
    head_s      = ent_q[0];
`endif
    ir_o_valid      = (count_q != 2'd0) & ~pipe_flush_req;
    push_s          = ifu_o_valid & ifu_o_ready & ~pipe_flush_req;
    pop_s           = ir_o_valid & ir_o_ready;
    ir_o_instr      = head_s.ir;
    ir_o_pc         = head_s.pc;
    ir_o_prdt_taken = head_s.prdt_taken;
    ir_o_misalgn    = head_s.misalgn;
    ir_o_buserr     = head_s.buserr;
    ir_o_muldiv_b2b = head_s.muldiv_b2b;
  end

  // Next occupancy, pointers and entry contents; a flush empties the
  // buffer but leaves the payload registers untouched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    count_d = count_q;
`ifdef E203_IRBUF_2DEPTH_EN
    wptr_d = wptr_q;
    rptr_d = rptr_q;
`endif
    if (pipe_flush_req) begin
      count_d = 2'd0;
`ifdef E203_IRBUF_2DEPTH_EN
      wptr_d = 1'b0;
      rptr_d = 1'b0;
`endif
    end else begin
      if (push_s) begin
`ifdef E203_IRBUF_2DEPTH_EN
        ent_d[wptr_q] = in_s;
        wptr_d        = ~wptr_q;
`else
        ent_d[0] = in_s;
`endif
      end else begin
`ifdef E203_IRBUF_2DEPTH_EN
        wptr_d = wptr_q;
`else
        ent_d[0] = ent_q[0];
`endif
      end
`ifdef E203_IRBUF_2DEPTH_EN
      if (pop_s) begin
        rptr_d = ~rptr_q;
      end else begin
        rptr_d = rptr_q;
      end
`endif
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // State registers with asynchronous clear of occupancy, pointers and payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
`ifdef E203_IRBUF_2DEPTH_EN
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
`ifdef E203_IRBUF_2DEPTH_EN
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
`endif
    end
  end

endmodule
